if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage fetch engine: owns the PC, issues word reads to instruction memory over req/ack,
//  buffers up to 2 fetched words, presents them (or a NOP bubble) to IF_ID's instr_in/PCplus4_in.
//  Applies branch/jump redirects from later stages; tolerates variable memory latency.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset (bits [1:0] must be 0)
//  CNT_W     32             width of bubble counter (FETCH_PERF_CNT_EN only)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  stall          in   1   hazard unit holds IF_ID; current output entry is not consumed
//  redirect_valid in   1   taken branch/jump this cycle
//  redirect_pc    in   32  redirect target; bits [1:0] ignored, treated as 00
//  imem_req       out  1   read request; held with imem_addr stable until imem_ack
//  imem_addr      out  32  word-aligned read address
//  imem_ack       in   1   1-cycle pulse: imem_rdata valid, completes current request
//  imem_rdata     in   32  instruction word
//  instr_out      out  32  to IF_ID instr_in; 32'h0 (NOP) when fetch_valid=0
//  PCplus4_out    out  32  to IF_ID PCplus4_in; entry PC+4, 32'h0 when fetch_valid=0
//  fetch_valid    out  1   head entry valid
//  bubble_cnt     out  CNT_W  (FETCH_PERF_CNT_EN only) see CONFIGURATION
// BEHAVIOUR
//  Reset: pc=RESET_PC, buffer empty, state IDLE, imem_req=0, imem_addr=0, outputs 0/NOP.
//  Buffer: 2 entries {pc,instr}; head drives outputs combinationally from registers.
//   consume = fetch_valid & ~stall (head popped at posedge). Push on accepted ack.
//  State IDLE: imem_req=0. Issue when count_next<2: req_addr<=pc, ->REQ.
//  State REQ: imem_req=1, imem_addr=req_addr.
//   ack & ~redirect: push {req_addr,rdata}; pc<=req_addr+4; if count_next<2 load req_addr<=pc+4
//     and stay REQ (back-to-back, imem_req stays 1), else ->IDLE.
//   redirect & ~ack: flush buffer, pc<=redirect_pc, ->DROP (req/addr held for in-flight read).
//   redirect & ack: discard rdata, flush, pc<=req_addr<=redirect_pc, stay REQ.
//  State DROP: imem_req=1, old addr held. ack: discard data, req_addr<=pc, ->REQ.
//   redirect in DROP: flush, pc<=redirect_pc, stay DROP (latest redirect wins).
//  Redirect beats stall and consume: buffer flushed same edge; fetch_valid=0 next cycle.
//  count_next = count - consume + push (after flush). Max 1 outstanding request.
//  Stall with buffer full: no request issued; PC frozen; outputs held exactly.
//  Latency: redirect -> first target word at fetch_valid = 1 cycle + memory latency (+ drain
//   of a dropped request). Zero-wait memory (ack same cycle as req) sustains 1 instr/cycle.
//  PC arithmetic mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no error.
//  Reset mid-request: state, buffer, pc cleared; a late ack after reset is ignored (IDLE).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: bubble_cnt port present; increments (saturating at all-ones)
//   each cycle with fetch_valid=0 & stall=0 & reset=1; cleared by reset.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  mips_pkg: NOP_INSTR=32'h0, fetch state enum {IDLE,REQ,DROP}, RESET_PC default.
//  Sub-module fetch_buf: 2-entry FIFO {pc,instr} with push, pop, flush (flush dominates).
// TESTING
//  Reset, zero-wait mem, no stall -> imem_addr 0,4,8,...; instr_out tracks mem[addr], PCplus4 4,8,12.
//  3-cycle-latency mem -> imem_req/addr stable until ack; fetch_valid=0 bubbles between words.
//  stall=1 for 5 cycles at PC=0x10 -> buffer fills (0x10,0x14), no further req, outputs held.
//  redirect to 0x200 while req for 0x08 pending -> 0x08 data dropped, next addr 0x200.
//  redirect and ack same cycle; redirect_pc=0x203 -> data discarded, imem_addr=0x200.
//  reset=0 during outstanding req, ack arrives next cycle -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants, state encoding and buffer entry type
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_fetch_buf.sv
// fetch_buf: 2-entry {pc,instr} FIFO with push, pop and a dominating flush
module fetch_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e0, e1;
  assign head = e0;
  always_ff @(posedge clk) begin
    if (!reset || flush) count <= '0;
    else count <= count + {1'b0, push} - {1'b0, pop};
    if (reset && !flush && (pop || (push && count == 2'd0))) e0 <= (pop && count == 2'd2) ? e1 : din;
    if (reset && !flush && push && count == (pop ? 2'd2 : 2'd1)) e1 <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage PC/imem req-ack fetch engine with 2-entry buffer; FETCH_PERF_CNT_EN adds bubble_cnt
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef FETCH_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] PCplus4_out,
  output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, req_addr, req_n, tgt, pc_eff;
  logic [1:0] count, count_n;
  logic consume, push, can_issue, unused_lsb;
  fetch_entry_t head, din;
  assign unused_lsb = ^redirect_pc[1:0];
  assign tgt = {redirect_pc[31:2], 2'b00};
  assign pc_eff = redirect_valid ? tgt : pc;
  assign fetch_valid = count != 2'd0;
  assign consume = fetch_valid & ~stall;
  assign push = (state == REQ) & imem_ack & ~redirect_valid;
  assign count_n = redirect_valid ? 2'd0 : count - {1'b0, consume} + {1'b0, push};
  assign can_issue = count_n < 2'd2;
  assign imem_req = state != IDLE;
  assign imem_addr = imem_req ? req_addr : '0;
  assign instr_out = fetch_valid ? head.instr : NOP_INSTR;
  assign PCplus4_out = fetch_valid ? head.pc + 32'd4 : '0;
  assign din = {req_addr, imem_rdata};
  always_comb begin
    state_n = state;
    pc_n = pc_eff;
    req_n = req_addr;
    if (state == IDLE) begin
      if (can_issue) begin
        req_n = pc_eff;
        state_n = REQ;
      end
    end else if (state == DROP) begin
      if (imem_ack) begin
        req_n = pc_eff;
        state_n = REQ;
      end
    end else if (redirect_valid) begin
      if (imem_ack) req_n = tgt;
      else state_n = DROP;
    end else if (imem_ack) begin
      pc_n = req_addr + 32'd4;
      if (can_issue) req_n = req_addr + 32'd4;
      else state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= req_n;
    end
  end
  fetch_buf u_buf (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(consume),
    .flush(redirect_valid),
    .din(din),
    .head(head),
    .count(count)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) bubble_cnt <= '0;
    else if (!fetch_valid && !stall && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
  end
`endif
endmodule
